pipe_adder: RTL and testbench

Parametrised, pipelined successor to the 8-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands. The carry chain is split into CHUNK-bit slices, with one slice resolved per pipeline stage, and a valid/ready handshake runs on both sides. It sits in the ALU datapath and provides carry, signed-overflow and zero flags for the flag register.

---
 rtl/alu_pkg.sv | 7 +
 rtl/adder_slice.sv | 14 +
 rtl/pipe_adder.sv | 120 ++++++++++++
 tb/tb_pipe_adder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: operation encoding for the sub port and default datapath sizing.
package alu_pkg;
  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;
  localparam int   ALU_WIDTH = 32;
  localparam int   ALU_CHUNK = 8;
endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit add with carry in/out; one instance per pipeline stage.
module adder_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = ALU_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one CHUNK-bit carry slice per stage, valid/ready on both sides,
// carry / signed-overflow / zero flags registered alongside the final sum.
module pipe_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CHUNK = ALU_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int MSB    = WIDTH - 1;

  logic adv;

  logic [STAGES-1:0]            r_v;
  logic [STAGES-1:0]            r_c;
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;
  logic [STAGES-1:0][WIDTH-1:0] r_s;
  logic                         r_ovf;
  logic                         r_zero;

  // st_* is what each stage sees on its input side; nxt_s is the running sum with slice k filled in
  logic [STAGES-1:0]            st_v;
  logic [STAGES-1:0]            st_c;
  logic [STAGES-1:0]            sl_c;
  logic [STAGES-1:0][WIDTH-1:0] st_a;
  logic [STAGES-1:0][WIDTH-1:0] st_b;
  logic [STAGES-1:0][WIDTH-1:0] st_s;
  logic [STAGES-1:0][WIDTH-1:0] nxt_s;

  assign adv      = !r_v[STAGES-1] || out_ready;
  assign in_ready = adv && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] sl_sum;
    logic [WIDTH-1:0] s_upd;

    if (k == 0) begin : g_first
      assign st_v[k] = in_valid;
      assign st_a[k] = a;
      assign st_b[k] = (sub == OP_SUB) ? ~b : b;
      assign st_s[k] = '0;
      assign st_c[k] = (sub == OP_SUB) ? 1'b1 : cin;
    end else begin : g_next
      assign st_v[k] = r_v[k-1];
      assign st_a[k] = r_a[k-1];
      assign st_b[k] = r_b[k-1];
      assign st_s[k] = r_s[k-1];
      assign st_c[k] = r_c[k-1];
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (st_a[k][k*CHUNK +: CHUNK]),
      .b    (st_b[k][k*CHUNK +: CHUNK]),
      .cin  (st_c[k]),
      .sum  (sl_sum),
      .cout (sl_c[k])
    );

    always_comb begin
      s_upd = st_s[k];
      s_upd[k*CHUNK +: CHUNK] = sl_sum;
    end

    assign nxt_s[k] = s_upd;
  end

  // Data registers only load on valid beats, so bubbles never disturb the output fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v    <= '0;
      r_c    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_s    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= st_v[k];
        if (st_v[k]) begin
          r_a[k] <= st_a[k];
          r_b[k] <= st_b[k];
          r_s[k] <= nxt_s[k];
          r_c[k] <= sl_c[k];
        end
      end
      if (st_v[STAGES-1]) begin
        r_ovf  <= (st_a[STAGES-1][MSB] == st_b[STAGES-1][MSB]) &&
                  (nxt_s[STAGES-1][MSB] != st_a[STAGES-1][MSB]);
        r_zero <= (nxt_s[STAGES-1] == '0);
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign overflow  = r_ovf;
  assign zero      = r_zero;

  // Last-stage operand copies have no consumer; keep them from looking like dangling logic.
  logic unused_skew;
  assign unused_skew = ^{r_a[STAGES-1], r_b[STAGES-1]};
endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: 32/8 configuration plus a single-stage 8/8 instance.
module tb_pipe_adder;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, zero;
  logic [31:0] a, b, sum;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, overflow8, zero8;
  logic [7:0] a8, b8, sum8;

  int vectors = 0;
  int miscompares = 0;

  pipe_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  pipe_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .overflow(overflow8), .zero(zero8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one beat, count edges until the result shows up, then check it and consume it.
  task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tcin, input logic tsub, input logic [31:0] es,
                       input logic ec, input logic eo, input logic ez);
    int n;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    chk({tag, ".in_ready"}, in_ready, 1'b1);
    n = 0;
    do begin
      tick();
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 12);
    chk({tag, ".latency"}, n, 4);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".overflow"}, overflow, eo);
    chk({tag, ".zero"}, zero, ez);
    tick();
  endtask

  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tcin, input logic tsub, input logic [7:0] es,
                      input logic ec, input logic eo, input logic ez);
    int n;
    a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub; in_valid8 = 1'b1;
    n = 0;
    do begin
      tick();
      in_valid8 = 1'b0;
      n++;
    end while (!out_valid8 && n < 6);
    chk({tag, ".latency"}, n, 1);
    chk({tag, ".sum"}, sum8, es);
    chk({tag, ".cout"}, cout8, ec);
    chk({tag, ".overflow"}, overflow8, eo);
    chk({tag, ".zero"}, zero8, ez);
    tick();
  endtask

  initial begin
    int stale;
    logic [31:0] exp_sum;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = OP_ADD; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = OP_ADD; out_ready8 = 1'b1;

    tick();
    tick();
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.sum", sum, 32'h0);
    chk("rst.cout", cout, 1'b0);
    chk("rst.overflow", overflow, 1'b0);
    chk("rst.zero", zero, 1'b0);
    chk("rst.out_valid8", out_valid8, 1'b0);

    rst = 1'b0;
    tick();
    chk("post_rst.in_ready", in_ready, 1'b1);

    run32("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run32("sub_borrow", 32'd5, 32'd7, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run32("sub_pos", 32'd7, 32'd5, 1'b0, OP_SUB, 32'd2, 1'b1, 1'b0, 1'b0);
    run32("sub_cin_ignored", 32'd7, 32'd5, 1'b1, OP_SUB, 32'd2, 1'b1, 1'b0, 1'b0);
    run32("add_cin", 32'd10, 32'd20, 1'b1, OP_ADD, 32'd31, 1'b0, 1'b0, 1'b0);
    run32("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run32("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run32("add_carry_chain", 32'h00FF_FF00, 32'h0000_0100, 1'b0, OP_ADD, 32'h0100_0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back beats, then a three-cycle downstream stall once the first result lands.
    for (int i = 1; i <= 4; i++) begin
      a = i; b = i; cin = 1'b0; sub = OP_ADD; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("stall.first_valid", out_valid, 1'b1);
    chk("stall.first_sum", sum, 32'd2);
    out_ready = 1'b0;
    #1;
    chk("stall.in_ready_drop", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.hold_valid", out_valid, 1'b1);
      chk("stall.hold_sum", sum, 32'd2);
      chk("stall.hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      exp_sum = 32'(2 * i);
      chk("stall.drain_valid", out_valid, 1'b1);
      chk("stall.drain_sum", sum, exp_sum);
    end
    tick();
    chk("stall.empty", out_valid, 1'b0);

    // Reset with three beats in flight; nothing stale may come out afterwards.
    for (int i = 1; i <= 3; i++) begin
      a = 32'(i * 256); b = 32'd1; sub = OP_ADD; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst.out_valid", out_valid, 1'b0);
    chk("midrst.in_ready", in_ready, 1'b0);
    rst = 1'b0;
    stale = 0;
    repeat (8) begin
      tick();
      if (out_valid) stale++;
    end
    chk("midrst.stale_beats", stale, 0);
    run32("midrst.fresh", 32'd10, 32'd20, 1'b0, OP_ADD, 32'd30, 1'b0, 1'b0, 1'b0);

    run8("w8_add", 8'd200, 8'd100, 1'b1, OP_ADD, 8'd45, 1'b1, 1'b0, 1'b0);
    run8("w8_sub_ovf", 8'h80, 8'h01, 1'b0, OP_SUB, 8'h7F, 1'b1, 1'b1, 1'b0);
    run8("w8_sub_zero", 8'h10, 8'h10, 1'b0, OP_SUB, 8'h00, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
